// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back queue: entry layout and address width.
// Pure declarations; no timing or flow control.
package regfile_wb_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 64;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_fwd.sv
// Forwarding lookup over pending entries; combinational. The youngest matching entry wins.
// Has no flow control: it only observes the queue and never stalls it.
module regfile_wb_fwd
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter bit ZERO_REG_ZERO = 1'b1,
    localparam int IDX_W        = $clog2(DEPTH)
) (
    input  wb_entry_t                 entries_i [DEPTH],
    input  logic [DEPTH-1:0]          age_vld_i,
    input  logic [IDX_W-1:0]          age_idx_i [DEPTH],
    input  logic [REG_ADDR_WIDTH-1:0] raddr_i,
    output logic                      hit_o,
    output logic [DATA_WIDTH-1:0]     data_o
);

    wb_entry_t w_ent;
    logic      w_lookup_ok;

    assign w_lookup_ok = !(ZERO_REG_ZERO && (raddr_i == '0));

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        w_ent  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_ent = entries_i[age_idx_i[k]];
            if (w_lookup_ok && age_vld_i[k] && (w_ent.addr == raddr_i)) begin
                hit_o  = 1'b1;
                data_o = w_ent.data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Buffers committed results and drains up to NR_WRITE_PORTS oldest entries per cycle to the register file; 1-cycle min latency.
// Backpressure: in_ready_o drops when full, from registered state only; drains free space the following cycle.
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = regfile_wb_pkg::DATA_WIDTH,
    parameter int NR_WRITE_PORTS = 2,
    parameter int NR_READ_PORTS  = 2,
    parameter int DEPTH          = 8,
    parameter bit ZERO_REG_ZERO  = 1'b1,
    localparam int IDX_W         = $clog2(DEPTH),
    localparam int PTR_W         = IDX_W + 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         in_valid_i,
    output logic                                         in_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0]                    in_addr_i,
    input  logic [DATA_WIDTH-1:0]                        in_data_i,
    input  logic                                         drain_en_i,
    output logic [NR_WRITE_PORTS-1:0][REG_ADDR_WIDTH-1:0] waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                    we_o,
    input  logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]  raddr_i,
    output logic [NR_READ_PORTS-1:0]                     fwd_hit_o,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]      fwd_data_o,
    output logic [PTR_W-1:0]                             count_o,
    output logic                                         empty_o,
    output logic                                         full_o
);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;

    logic [PTR_W-1:0] w_count;
    logic             w_full;
    logic             w_enq;
    logic             w_store;
    logic [PTR_W-1:0] w_n_avail;
    logic [PTR_W-1:0] w_n_pop;
    logic [IDX_W-1:0] w_age_idx [DEPTH];
    logic [DEPTH-1:0] w_age_vld;

    assign w_count = r_wptr - r_rptr;
    assign w_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);

    assign count_o    = w_count;
    assign empty_o    = (w_count == '0);
    assign full_o     = w_full;
    assign in_ready_o = !w_full;

    // x0 writes still complete the handshake but are dropped here.
    assign w_enq   = in_valid_i && in_ready_o;
    assign w_store = w_enq && !(ZERO_REG_ZERO && (in_addr_i == '0));

    assign w_n_avail = (w_count > PTR_W'(NR_WRITE_PORTS)) ? PTR_W'(NR_WRITE_PORTS) : w_count;
    assign w_n_pop   = drain_en_i ? w_n_avail : '0;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_age_idx[k] = r_rptr[IDX_W-1:0] + IDX_W'(k);
            w_age_vld[k] = (PTR_W'(k) < w_count);
        end
    end

    // Port 0 carries the oldest entry so higher-port-wins keeps program order.
    for (genvar p = 0; p < NR_WRITE_PORTS; p++) begin : g_wport
        logic w_has;
        assign w_has      = (PTR_W'(p) < w_n_avail);
        assign waddr_o[p] = w_has ? r_mem[w_age_idx[p]].addr : '0;
        assign wdata_o[p] = w_has ? r_mem[w_age_idx[p]].data : '0;
        assign we_o[p]    = w_has && drain_en_i;
    end

    for (genvar r = 0; r < NR_READ_PORTS; r++) begin : g_fwd
        regfile_wb_fwd #(
            .DEPTH         (DEPTH),
            .ZERO_REG_ZERO (ZERO_REG_ZERO)
        ) u_fwd (
            .entries_i (r_mem),
            .age_vld_i (w_age_vld),
            .age_idx_i (w_age_idx),
            .raddr_i   (raddr_i[r]),
            .hit_o     (fwd_hit_o[r]),
            .data_o    (fwd_data_o[r])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_mem[r_wptr[IDX_W-1:0]] <= '{addr: in_addr_i, data: in_data_i};
                r_wptr                   <= r_wptr + PTR_W'(1);
            end
            r_rptr <= r_rptr + w_n_pop;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, ordered drain, backpressure, forwarding, x0, wrap.
module tb_regfile_wb_queue;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [63:0]      in_data;
    logic             drain_en;
    logic [1:0][4:0]  waddr;
    logic [1:0][63:0] wdata;
    logic [1:0]       we;
    logic [1:0][4:0]  raddr;
    logic [1:0]       fwd_hit;
    logic [1:0][63:0] fwd_data;
    logic [3:0]       count;
    logic             empty;
    logic             full;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_queue dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_addr_i  (in_addr),
        .in_data_i  (in_data),
        .drain_en_i (drain_en),
        .waddr_o    (waddr),
        .wdata_o    (wdata),
        .we_o       (we),
        .raddr_i    (raddr),
        .fwd_hit_o  (fwd_hit),
        .fwd_data_o (fwd_data),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int got;
        int maxc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b0;
        raddr    = '0;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_hit", fwd_hit, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        rst_n = 1'b1;
        tick();

        // Reset mid-burst
        push(5, 64'h11);
        push(6, 64'h22);
        push(7, 64'h33);
        chk("burst_count", count, 3);
        drain_en = 1'b1;
        #1;
        chk("burst_we_pre", we, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_we", we, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_we", we, 0);
        chk("post_rst_count", count, 0);
        drain_en = 1'b0;

        // Ordered drain
        push(3, 64'hA);
        push(3, 64'hB);
        push(4, 64'hC);
        chk("ord_count", count, 3);
        drain_en = 1'b1;
        #1;
        chk("ord_c1_we", we, 2'b11);
        chk("ord_c1_a0", waddr[0], 3);
        chk("ord_c1_d0", wdata[0], 64'hA);
        chk("ord_c1_a1", waddr[1], 3);
        chk("ord_c1_d1", wdata[1], 64'hB);
        tick();
        chk("ord_c2_we", we, 2'b01);
        chk("ord_c2_a0", waddr[0], 4);
        chk("ord_c2_d0", wdata[0], 64'hC);
        tick();
        chk("ord_empty", empty, 1);
        chk("ord_we_idle", we, 0);
        drain_en = 1'b0;

        // Full and backpressure
        for (int i = 1; i <= 8; i++) push(5'(i), 64'(i * 16));
        chk("full_flag", full, 1);
        chk("full_count", count, 8);
        in_valid = 1'b1;
        in_addr  = 5'd9;
        in_data  = 64'h99;
        #1;
        chk("full_ready", in_ready, 0);
        tick();
        chk("full_hold_count", count, 8);
        drain_en = 1'b1;
        #1;
        chk("full_drain_a0", waddr[0], 1);
        chk("full_drain_a1", waddr[1], 2);
        tick();
        drain_en = 1'b0;
        chk("free_count", count, 6);
        chk("free_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("x9_count", count, 7);
        raddr[0] = 5'd9;
        #1;
        chk("x9_hit", fwd_hit[0], 1);
        chk("x9_data", fwd_data[0], 64'h99);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        drain_en = 1'b0;
        chk("full_flush_empty", empty, 1);

        // Forwarding: youngest wins, draining entries still hit
        push(10, 64'h100);
        push(10, 64'h200);
        raddr[0] = 5'd10;
        raddr[1] = 5'd11;
        #1;
        chk("fwd_hit", fwd_hit, 2'b01);
        chk("fwd_d0", fwd_data[0], 64'h200);
        chk("fwd_d1", fwd_data[1], 0);
        drain_en = 1'b1;
        #1;
        chk("fwd_drain_hit", fwd_hit, 2'b01);
        chk("fwd_drain_d0", fwd_data[0], 64'h200);
        tick();
        drain_en = 1'b0;
        chk("fwd_after_hit", fwd_hit, 0);
        chk("fwd_after_d0", fwd_data[0], 0);

        // x0 discard
        in_valid = 1'b1;
        in_addr  = 5'd0;
        in_data  = 64'hDEAD;
        #1;
        chk("x0_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        raddr[0] = 5'd0;
        #1;
        chk("x0_count", count, 0);
        chk("x0_empty", empty, 1);
        chk("x0_hit", fwd_hit[0], 0);

        // Wrap-around with concurrent enqueue and drain
        got      = 0;
        maxc     = 0;
        drain_en = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c < 20) begin
                in_valid = 1'b1;
                in_addr  = 5'(c + 1);
                in_data  = 64'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (int'(count) > maxc) maxc = int'(count);
            for (int p = 0; p < 2; p++) begin
                if (we[p]) begin
                    got++;
                    chk("wrap_addr", waddr[p], 64'(got));
                    chk("wrap_data", wdata[p], 64'(got));
                end
            end
            tick();
        end
        drain_en = 1'b0;
        chk("wrap_pulses", 64'(got), 20);
        chk("wrap_max_le2", 64'(maxc <= 2), 1);
        chk("wrap_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side feeder for the flip-flop integer register file: buffers committed results and drains them onto the register file's multi-port write interface (waddr/wdata/we).
- Decouples commit bursts from write-port availability.
- Provides read-side forwarding of pending, not-yet-written values so operand reads stay coherent.

Parameters:
- DATA_WIDTH, 64, register width in bits.
- NR_WRITE_PORTS, 2, register-file write ports driven per cycle (matches commit port count).
- NR_READ_PORTS, 2, forwarding lookup ports.
- DEPTH, 8, queue entries; power of two, at least NR_WRITE_PORTS.
- ZERO_REG_ZERO, 1, discard writes to x0 at enqueue.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  committed write request valid.
- in_ready_o  out  1  queue can accept.
- in_addr_i  in  5  destination register.
- in_data_i  in  DATA_WIDTH  result value.
- drain_en_i  in  1  register file may be written this cycle.
- waddr_o  out  NR_WRITE_PORTS x 5  write addresses; port 0 = oldest.
- wdata_o  out  NR_WRITE_PORTS x DATA_WIDTH  write data.
- we_o  out  NR_WRITE_PORTS  write enables.
- raddr_i  in  NR_READ_PORTS x 5  lookup addresses.
- fwd_hit_o  out  NR_READ_PORTS  pending entry matches.
- fwd_data_o  out  NR_READ_PORTS x DATA_WIDTH  youngest matching pending data.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.

Behaviour:
- Reset (async, rst_ni low): pointers and count cleared; in_ready_o=1, we_o=0, fwd_hit_o=0, count_o=0, empty_o=1, full_o=0. Reset mid-operation discards pending entries; no partial drain.
- Storage: circular buffer of {addr, data}. Read/write pointers are $clog2(DEPTH)+1 bits. Wrap by MSB toggle; full when MSBs differ and the low bits are equal.
- Enqueue: handshake completes on in_valid_i & in_ready_o at the rising edge. in_ready_o = !full_o, computed from registered count only; a drain in the same cycle does not free space for the same cycle.
- x0 handling (ZERO_REG_ZERO=1): in_addr_i==0 completes the handshake but is not stored, and count is unchanged. With ZERO_REG_ZERO=0, x0 writes are stored and drained like any other register.
- Drain:
  - Combinational from the head: n = min(count, NR_WRITE_PORTS). Ports 0..n-1 show the oldest entries in age order with we_o=1 only when drain_en_i=1; the remaining ports show we_o=0.
  - Popped at the edge when drain_en_i=1.
  - Age order on ports lets the register file's higher-port-wins rule preserve program order for same-address entries.
- Latency: an accepted entry appears on we_o no earlier than the next cycle. There is no enqueue-to-write bypass in the same cycle.
- Simultaneous enqueue and drain: count_next = count + enq - n_popped.
- Forwarding:
  - Combinational search per read port over stored entries only, youngest to oldest. Entries being drained this cycle still hit.
  - raddr_i==0 never hits when ZERO_REG_ZERO=1.
  - fwd_data_o is 0 when there is no hit.
- No x-propagation on outputs: invalid storage slots never contribute to hits.

Decomposition:
- Shared package regfile_wb_pkg: wb_entry_t struct {logic [4:0] addr; logic [DATA_WIDTH-1:0] data} (parameterised via the package's DATA_WIDTH constant); REG_ADDR_WIDTH=5 constant.
- One combinational sub-module, regfile_wb_fwd, instantiated per read port. Inputs: entry array, valid mask, age-ordered index, lookup address. Outputs: hit and data from the youngest match via a priority mux.

Test Plan:
- Reset mid-burst:
  - Stimulus: enqueue x5=0x11, x6=0x22, x7=0x33 with drain_en_i=0, then pulse rst_ni low.
  - Required: count_o=0, empty_o=1, we_o=0 immediately (async); after release no writes occur.
- Ordered drain:
  - Stimulus: enqueue x3=0xA, x3=0xB, x4=0xC, then drain_en_i=1.
  - Cycle 1: port0 x3=0xA and port1 x3=0xB. Cycle 2: port0 x4=0xC, we_o=2'b01. Then empty_o=1.
- Full and backpressure:
  - Stimulus: with DEPTH=8 and drain_en_i=0, enqueue 8 entries to x1..x8, then hold in_valid_i with x9.
  - Required: full_o=1, in_ready_o=0, x9 not accepted.
  - Then drain_en_i=1 for one cycle: count_o=6 and in_ready_o=1 the next cycle; x9 accepted afterwards.
- Forwarding youngest wins:
  - Stimulus: pending x10=0x100, then x10=0x200; raddr_i[0]=10, raddr_i[1]=11.
  - Required: fwd_hit_o=2'b01, fwd_data_o[0]=0x200, fwd_data_o[1]=0.
- x0 discard:
  - Stimulus: enqueue x0=0xDEAD with ZERO_REG_ZERO=1.
  - Required: handshake completes, count_o stays 0, and raddr_i=0 gives fwd_hit_o=0.
- Wrap-around with concurrent enqueue and drain:
  - Stimulus: stream 20 sequential writes x1..x20 with data=index, one per cycle, drain_en_i=1 continuously.
  - Required: exactly 20 we_o pulses in order with data 1..20, count_o never above 2, no losses across pointer wrap.
